// File: rtl/ad7768_rx.sv
// ---------------------------------------------------------------------------
// ad7768_rx
//
// Target-side capture for the 8-lane AD7768 serial data interface. Drives the
// ADC sync line, registers the eight data lanes plus drdy, deserializes one
// 32-bit word per lane per frame, checks each word's header and hands the
// eight samples to the framing logic as a valid/ready stream of 20-bit words.
//
// Ports
//   clock       ADC/target clock (shared with the ADCs)
//   reset_n     asynchronous active-low reset
//   sync_start  one-cycle request: resync the ADCs, clear sticky flags
//   sync_n      ADC sync, active low, SYNC_CYCLES clocks long
//   d[7:0]      serial lanes, lane i = ADC channel i, MSB first, 4 clk/bit
//   drdy        from ADC 0, high during the LSB bit period of each frame
//   out_data    {err, channel[2:0], sample[15:0]}
//   out_valid   stream valid
//   out_ready   stream ready
//   locked      frame alignment acquired
//   frame_err   sticky: wrong frame length or missing drdy
//   overflow    sticky: frame dropped because the buffer was still full
//
// Sync FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | sync_n high, strobes enabled, waiting for sync_start
//   ST_SYNC | sync_n low for SYNC_CYCLES clocks, strobes suppressed
// ---------------------------------------------------------------------------
module ad7768_rx #(
    parameter int SYNC_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sync_start,
    output logic        sync_n,
    input  logic [7:0]  d,
    input  logic        drdy,
    output logic [19:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        locked,
    output logic        frame_err,
    output logic        overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SYNC = 1'b1
    } sync_state_t;

    sync_state_t state, state_nxt;
    logic [3:0]  sync_cnt, sync_cnt_nxt;
    logic        sync_go;

    logic [7:0]  d_r;
    logic        drdy_r;
    logic        drdy_q;

    logic [1:0]  phase;
    logic        drdy_rise;
    logic        strobe;
    logic        frame_end;

    // Only 31 bits of history are kept: the 32nd bit of a word is the lane
    // value sampled on the frame-end strobe itself.
    logic [7:0][30:0] shift;
    logic [5:0]       bit_cnt;

    logic [7:0][31:0] word;
    logic [7:0]       hdr_err;
    logic [7:0][19:0] entry_new;
    logic [7:0][19:0] entry;

    logic [2:0]  rd_ptr;
    logic        buf_valid;
    logic        last_take;
    logic        buf_free;
    logic        frame_ok;
    logic        load;
    logic        drop_full;

    // -----------------------------------------------------------------------
    // Sync FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sync_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            sync_cnt <= sync_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sync_cnt_nxt = sync_cnt;
        sync_go      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sync_start) begin
                    state_nxt    = ST_SYNC;
                    sync_cnt_nxt = 4'(SYNC_CYCLES - 1);
                    sync_go      = 1'b1;
                end
            end
            ST_SYNC: begin
                if (sync_cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    sync_cnt_nxt = sync_cnt - 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sync_n = (state != ST_SYNC);

    // -----------------------------------------------------------------------
    // Input registers and strobe phase
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_r    <= 8'd0;
            drdy_r <= 1'b0;
            drdy_q <= 1'b0;
        end else begin
            d_r    <= d;
            drdy_r <= drdy;
            drdy_q <= drdy_r;
        end
    end

    assign drdy_rise = drdy_r & ~drdy_q;

    // A drdy rise forces phase to 0 on the next clock, so phase==1 lands two
    // clocks after the rise: mid-bit of the LSB period, then every 4 clocks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase <= 2'd0;
        end else if (drdy_rise) begin
            phase <= 2'd0;
        end else begin
            phase <= phase + 2'd1;
        end
    end

    assign strobe    = (phase == 2'd1) && (state == ST_IDLE);
    assign frame_end = strobe & drdy_r;

    // -----------------------------------------------------------------------
    // Word assembly and header check
    // -----------------------------------------------------------------------
    always_comb begin
        word      = '0;
        hdr_err   = '0;
        entry_new = '0;
        for (int i = 0; i < 8; i++) begin
            word[i]      = {shift[i], d_r[i]};
            hdr_err[i]   = ~((word[i][31:27] == 5'h10) &&
                             (word[i][26:24] == 3'(i)) &&
                             (word[i][23:19] == 5'h10) &&
                             (word[i][18:16] == 3'(i)));
            entry_new[i] = {hdr_err[i], 3'(i), word[i][15:0]};
        end
    end

    // bit_cnt counts strobes before this one, so a 32-bit frame ends with 31.
    assign frame_ok  = frame_end & locked & (bit_cnt == 6'd31);

    // Handing over the last buffered word in the frame-end cycle frees the
    // buffer for the new frame.
    assign last_take = buf_valid & out_ready & (rd_ptr == 3'd7);
    assign buf_free  = ~buf_valid | last_take;
    assign load      = frame_ok & buf_free & ~sync_go;
    assign drop_full = frame_ok & ~buf_free & ~sync_go;

    // -----------------------------------------------------------------------
    // Shift registers, bit counter, alignment and sticky flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift     <= '0;
            bit_cnt   <= 6'd0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else if (sync_go) begin
            shift     <= '0;
            bit_cnt   <= 6'd0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (strobe) begin
                for (int i = 0; i < 8; i++) begin
                    shift[i] <= word[i][30:0];
                end
                if (drdy_r) begin
                    bit_cnt <= 6'd0;
                    if (!locked) begin
                        locked <= 1'b1;
                    end else if (bit_cnt != 6'd31) begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    if (bit_cnt != 6'd63) begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                    // This strobe takes the count to 33 with no frame end.
                    if (bit_cnt == 6'd32) begin
                        locked    <= 1'b0;
                        frame_err <= 1'b1;
                    end
                end
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Holding buffer and emission; a resync does not cut an emission short.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry     <= '0;
            rd_ptr    <= 3'd0;
            buf_valid <= 1'b0;
        end else begin
            if (buf_valid && out_ready) begin
                if (rd_ptr == 3'd7) begin
                    buf_valid <= 1'b0;
                    rd_ptr    <= 3'd0;
                end else begin
                    rd_ptr <= rd_ptr + 3'd1;
                end
            end
            if (load) begin
                entry     <= entry_new;
                rd_ptr    <= 3'd0;
                buf_valid <= 1'b1;
            end
        end
    end

    assign out_valid = buf_valid;
    assign out_data  = buf_valid ? entry[rd_ptr] : 20'd0;

endmodule

// File: tb/tb_ad7768_rx.sv
// ---------------------------------------------------------------------------
// tb_ad7768_rx
//
// Directed bench for ad7768_rx. Eight ADC models share one free-running frame
// timer (128 clocks per frame, drdy during the LSB bit). Every lane sends
// {5'h10, ch, 5'h10, ch, frame_count}. A single negedge process drives the
// lanes, computes out_ready from the stall window and records every accepted
// word with its cycle number; the main sequence checks the recorded words.
// ---------------------------------------------------------------------------
module tb_ad7768_rx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_start = 1'b0;
    logic        sync_n;
    logic [7:0]  d = 8'd0;
    logic        drdy = 1'b0;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        locked;
    logic        frame_err;
    logic        overflow;

    ad7768_rx #(.SYNC_CYCLES(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sync_start (sync_start),
        .sync_n     (sync_n),
        .d          (d),
        .drdy       (drdy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .locked     (locked),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ADC model and stream monitor state
    int          ncyc = 0;
    int          pos = 127;
    logic [15:0] fcnt = 16'hFFFF;
    logic        drdy_en = 1'b1;
    logic        drdy_gate = 1'b1;
    logic [15:0] bad_cnt = 16'hFFFF;
    logic [31:0] adc_w;
    int          stall_start = -1000;
    int          stall_len = 0;
    int          stall_bad = 0;
    int          stall_seen = 0;
    logic [19:0] stall_word = 20'd0;
    logic        stall_have = 1'b0;
    logic [19:0] rx_q[$];
    int          rx_cyc[$];
    int          rise_cyc[64];
    bit          rise_seen[64];

    function automatic logic [31:0] adc_word(input int lane, input logic [15:0] cnt, input logic bad);
        logic [2:0] ch;
        ch = 3'(lane);
        return {5'h10, (bad ? 3'd2 : ch), 5'h10, ch, cnt};
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            ncyc++;
            out_ready = !((ncyc >= stall_start) && (ncyc < stall_start + stall_len));
            if (out_valid && !out_ready) begin
                stall_seen++;
                if (stall_have && (out_data !== stall_word)) stall_bad++;
                stall_word = out_data;
                stall_have = 1'b1;
            end else begin
                stall_have = 1'b0;
            end
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                rx_cyc.push_back(ncyc);
            end
            pos = (pos == 127) ? 0 : pos + 1;
            if (pos == 0) begin
                fcnt++;
                drdy_gate = drdy_en;
            end
            for (int i = 0; i < 8; i++) begin
                adc_w = adc_word(i, fcnt, (i == 5) && (fcnt == bad_cnt));
                d[i] = adc_w[5'(31 - pos / 4)];
            end
            drdy = drdy_gate && (pos >= 124);
            if (drdy_gate && (pos == 124) && (fcnt < 16'd64)) begin
                rise_cyc[fcnt[5:0]]  = ncyc;
                rise_seen[fcnt[5:0]] = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_until(input int cyc);
        while (ncyc < cyc) step();
    endtask

    task automatic wait_frame(input int c);
        int guard = 0;
        while (!rise_seen[c] && guard < 2000) begin
            step();
            guard++;
        end
        check($sformatf("frame%0d_drdy_seen", c), 32'(rise_seen[c]), 32'd1);
    endtask

    // Pops eight words and compares them to {err_mask[i], i, cnt}; with lat
    // set, channel i must have been taken at drdy-rise + 4 + i.
    task automatic check_frame(input int cnt, input logic [7:0] err_mask, input bit lat);
        int          guard = 0;
        logic [19:0] w;
        logic [19:0] exp;
        int          c;
        while (rx_q.size() < 8 && guard < 1000) begin
            step();
            guard++;
        end
        check($sformatf("frame%0d_words_arrived", cnt), 32'(rx_q.size() >= 8), 32'd1);
        if (rx_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                exp = {err_mask[i], 3'(i), 16'(cnt)};
                w   = rx_q.pop_front();
                c   = rx_cyc.pop_front();
                check($sformatf("frame%0d_ch%0d_data", cnt, i), 32'(w), 32'(exp));
                if (lat) check($sformatf("frame%0d_ch%0d_cycle", cnt, i), c, rise_cyc[cnt] + 4 + i);
            end
        end
    endtask

    task automatic pulse_sync();
        sync_start = 1'b1;
        step();
        sync_start = 1'b0;
    endtask

    initial begin
        int low;

        // Reset values
        step();
        step();
        check("rst_sync_n", 32'(sync_n), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        step();

        // Sync and lock
        pulse_sync();
        low = 0;
        for (int k = 0; k < 10; k++) begin
            if (!sync_n) low++;
            step();
        end
        check("sync_low_len", low, 4);
        check("sync_locked", 32'(locked), 32'd0);
        wait_frame(0);
        wait_until(rise_cyc[0] + 6);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_frame_err", 32'(frame_err), 32'd0);
        check("lock_partial_dropped", rx_q.size(), 0);
        check_frame(1, 8'h00, 1'b1);

        // Backpressure: 50-cycle stall starting on channel 2 of frame 2
        stall_bad   = 0;
        stall_seen  = 0;
        stall_start = rise_cyc[1] + 128 + 6;
        stall_len   = 50;
        check_frame(2, 8'h00, 1'b0);
        check("stall_data_stable", stall_bad, 0);
        check("stall_cycles", stall_seen, 50);
        check_frame(3, 8'h00, 1'b1);

        // Last word of frame 4 taken in the same cycle frame 5 ends
        stall_start = rise_cyc[3] + 128 + 4;
        stall_len   = 120;
        check_frame(4, 8'h00, 1'b0);
        check_frame(5, 8'h00, 1'b1);
        check("simul_no_overflow", 32'(overflow), 32'd0);

        // Overflow: frame 6 held, frame 7 dropped, frame 8 accepted
        stall_start = ncyc + 1;
        stall_len   = 300;
        check_frame(6, 8'h00, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_frame_err", 32'(frame_err), 32'd0);
        check_frame(8, 8'h00, 1'b1);
        pulse_sync();
        check("sync2_sync_n", 32'(sync_n), 32'd0);
        check("sync2_ovf_clear", 32'(overflow), 32'd0);
        check("sync2_unlocked", 32'(locked), 32'd0);
        check_frame(10, 8'h00, 1'b1);

        // Header error on lane 5 of frame 12
        bad_cnt = 16'd12;
        check_frame(11, 8'h00, 1'b1);
        check_frame(12, 8'h20, 1'b1);
        check("hdr_no_frame_err", 32'(frame_err), 32'd0);

        // Missing drdy: frames 14 and 15 carry no drdy
        drdy_en = 1'b0;
        check_frame(13, 8'h00, 1'b1);
        wait_until(rise_cyc[13] + 120);
        check("miss_early_locked", 32'(locked), 32'd1);
        check("miss_early_frame_err", 32'(frame_err), 32'd0);
        wait_until(rise_cyc[13] + 200);
        check("miss_locked", 32'(locked), 32'd0);
        check("miss_frame_err", 32'(frame_err), 32'd1);
        drdy_en = 1'b1;
        check_frame(17, 8'h00, 1'b1);
        check("miss_frame_err_sticky", 32'(frame_err), 32'd1);
        check("miss_relocked", 32'(locked), 32'd1);

        // Reset while channel 3 of frame 18 is on the output
        wait_frame(18);
        wait_until(rise_cyc[18] + 6);
        check("midrst_pre_ch3", 32'(out_data), {12'd0, 1'b0, 3'd3, 16'd18});
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_sync_n", 32'(sync_n), 32'd1);
        check("midrst_words_before", rx_q.size(), 3);
        rx_q.delete();
        rx_cyc.delete();
        step();
        step();
        step();
        reset_n = 1'b1;
        wait_frame(19);
        wait_until(rise_cyc[19] + 20);
        check("midrst_no_words_until_lock", rx_q.size(), 0);
        check("midrst_relocked", 32'(locked), 32'd1);
        check_frame(20, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
